// File: rtl/heavyhash_mat_ctrl_if.sv
// Handshake bundle between the heavyhash matrix controller and its FIFOs, column RAMs and PEs.
// The master side is the controller; the slave side is the surrounding datapath.
interface heavyhash_mat_ctrl_if #(
    parameter int N_COLS    = 64,
    parameter int N_ROWS    = 64,
    parameter int OUT_WORDS = 4
) ();
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int OUT_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    logic              m_empty;
    logic              m_re;
    logic              m_ram_we;
    logic [N_COLS-1:0] en_column;
    logic [ROW_W-1:0]  ram_addr;
    logic              hashin_empty;
    logic              hashin_re;
    logic              PE_en;
    logic              PE_clr;
    logic              PE_last;
    logic              out_full;
    logic              hashout_we;
    logic [OUT_W-1:0]  out_sel;
    logic              matrix_valid;
    logic              busy;
    logic [31:0]       hash_count;

    modport master (
        input  m_empty, hashin_empty, out_full,
        output m_re, m_ram_we, en_column, ram_addr, hashin_re, PE_en, PE_clr, PE_last,
               hashout_we, out_sel, matrix_valid, busy, hash_count
    );

    modport slave (
        output m_empty, hashin_empty, out_full,
        input  m_re, m_ram_we, en_column, ram_addr, hashin_re, PE_en, PE_clr, PE_last,
               hashout_we, out_sel, matrix_valid, busy, hash_count
    );
endinterface

// File: rtl/heavyhash_mat_ctrl.sv
// Control FSM for the heavyhash matrix multiplier: matrix load, per-hash multiply beats,
// PE strobe alignment to RAM read latency, and result drain.
module heavyhash_mat_ctrl #(
    parameter int N_COLS    = 64,
    parameter int N_ROWS    = 64,
    parameter int OUT_WORDS = 4,
    parameter int RD_LAT    = 2
) (
    input logic                  clk,
    input logic                  rst,
    heavyhash_mat_ctrl_if.master bus
);
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int OUT_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int FL_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST = OUT_W'(OUT_WORDS - 1);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(RD_LAT - 1);
    localparam logic [N_COLS-1:0] COL_ONE  = N_COLS'(1);

    typedef enum logic [2:0] {IDLE, M_LOAD, MULT, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  beat;
    logic [OUT_W-1:0]  word;
    logic [FL_W-1:0]   flush_cnt;
    logic              mat_valid;
    logic [31:0]       hashes;
    logic [RD_LAT-1:0] vld_dl;
    logic [RD_LAT-1:0] last_dl;

    logic load_beat;
    logic mult_beat;
    logic drain_beat;

    assign load_beat  = (state == M_LOAD) && !bus.m_empty;
    assign mult_beat  = (state == MULT) && !bus.hashin_empty;
    assign drain_beat = (state == DRAIN) && !bus.out_full;

    always_comb begin
        bus.m_re       = load_beat;
        bus.m_ram_we   = load_beat;
        bus.hashin_re  = mult_beat;
        bus.hashout_we = drain_beat;
        bus.PE_clr     = (state == IDLE);
        bus.busy       = (state != IDLE);
        bus.en_column  = '0;
        bus.ram_addr   = '0;
        bus.out_sel    = '0;
        case (state)
            M_LOAD: begin
                bus.ram_addr = row;
                if (load_beat) bus.en_column = COL_ONE << col;
            end
            MULT: begin
                bus.ram_addr = beat;
                if (mult_beat) bus.en_column = '1;
            end
            DRAIN:   bus.out_sel = word;
            default: ;
        endcase
    end

    // PE strobes are the tail of a shift line so they land with the RAM data.
    assign bus.PE_en        = vld_dl[RD_LAT-1];
    assign bus.PE_last      = last_dl[RD_LAT-1];
    assign bus.matrix_valid = mat_valid;
    assign bus.hash_count   = hashes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            beat      <= '0;
            word      <= '0;
            flush_cnt <= '0;
            mat_valid <= 1'b0;
            hashes    <= '0;
            vld_dl    <= '0;
            last_dl   <= '0;
        end else begin
            vld_dl  <= (vld_dl << 1) | RD_LAT'(mult_beat);
            last_dl <= (last_dl << 1) | RD_LAT'(mult_beat && (beat == ROW_LAST));
            case (state)
                IDLE: begin
                    // A pending matrix always wins over a pending hash.
                    if (!bus.m_empty) begin
                        row       <= '0;
                        col       <= '0;
                        mat_valid <= 1'b0;
                        state     <= M_LOAD;
                    end else if (mat_valid && !bus.hashin_empty) begin
                        beat  <= '0;
                        state <= MULT;
                    end
                end
                M_LOAD: begin
                    if (load_beat) begin
                        if (row == ROW_LAST) begin
                            row <= '0;
                            if (col == COL_LAST) begin
                                mat_valid <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (mult_beat) begin
                        if (beat == ROW_LAST) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        word  <= '0;
                        state <= DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_beat) begin
                        if (word == OUT_LAST) begin
                            hashes <= hashes + 32'd1;
                            state  <= IDLE;
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heavyhash_mat_ctrl.sv
// Bench for heavyhash_mat_ctrl: FIFO-like random stimulus, event-level reference model
// of load order, beat-to-PE latency, drain order and hash counting.
module tb_heavyhash_mat_ctrl;
    localparam int NC = 64;
    localparam int NR = 64;
    localparam int OW = 4;
    localparam int RL = 2;
    localparam int MAT_WORDS = NC * NR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    heavyhash_mat_ctrl_if #(.N_COLS(NC), .N_ROWS(NR), .OUT_WORDS(OW)) bus ();

    heavyhash_mat_ctrl #(.N_COLS(NC), .N_ROWS(NR), .OUT_WORDS(OW), .RD_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit m_emp  = 1'b1;
    bit h_emp  = 1'b1;
    bit o_full = 1'b0;
    assign bus.m_empty      = m_emp;
    assign bus.hashin_empty = h_emp;
    assign bus.out_full     = o_full;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // stimulus controls (written by the main sequence only)
    int m_goal = 0, h_goal = 0;
    bit m_rand = 0, h_rand = 0, of_rand = 0, tog_mode = 0, of_mode = 0;
    bit tog = 0;

    // model state (written by the monitor only)
    int cyc = 0;
    int n_mre = 0, n_hre = 0, n_pe = 0, n_we = 0;
    int load_k = 0, loads_done = 0, mult_k = 0, pe_cnt = 0, wr_k = 0, hc_exp = 0;
    int last_wr_cyc = -100, gap_last = 0, pe_last_cyc = -100, full_stall = 0;
    bit mv_next = 0;
    int q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_emp = (m_goal == n_mre) || (m_rand && $urandom_range(2) == 0);
        if (h_goal == n_hre) h_emp = 1'b1;
        else if (tog_mode)   h_emp = tog;
        else                 h_emp = h_rand && ($urandom_range(1) == 1);
        tog = !tog;
        o_full = (of_mode && (cyc - pe_last_cyc) >= 1 && (cyc - pe_last_cyc) <= 10)
                 || (of_rand && $urandom_range(3) == 0);
    end

    always @(negedge clk) begin
        int t0;
        if (rst) begin
            q.delete();
            load_k = 0; mult_k = 0; pe_cnt = 0; wr_k = 0; hc_exp = 0; mv_next = 0;
        end else begin
            chk("pe_clr_iff_idle", bus.PE_clr, !bus.busy);
            chk("hash_count", bus.hash_count, hc_exp);
            chk("m_re_guard", bus.m_re & bus.m_empty, 0);
            chk("hashin_re_guard", bus.hashin_re & bus.hashin_empty, 0);
            chk("hashout_we_guard", bus.hashout_we & bus.out_full, 0);
            if (mv_next) begin
                chk("mv_rise", bus.matrix_valid, 1);
                mv_next = 0;
            end
            if (bus.m_re) begin
                chk("load_we", bus.m_ram_we, 1);
                chk("load_col", bus.en_column, 64'(1) << (load_k / NR));
                chk("load_row", bus.ram_addr, load_k % NR);
                chk("load_mv_low", bus.matrix_valid, 0);
                chk("load_during_hash", mult_k + pe_cnt + wr_k + q.size(), 0);
                load_k++; n_mre++;
                if (load_k == MAT_WORDS) begin
                    load_k = 0; loads_done++; mv_next = 1;
                end
            end else begin
                chk("ram_we_idle", bus.m_ram_we, 0);
            end
            if (bus.hashin_re) begin
                chk("mult_cols", bus.en_column, {64{1'b1}});
                chk("mult_addr", bus.ram_addr, mult_k);
                chk("mult_mv", bus.matrix_valid, 1);
                chk("mult_during_load", load_k, 0);
                if (mult_k == 0) begin
                    chk("load_priority", m_goal - n_mre, 0);
                    gap_last = cyc - last_wr_cyc;
                end
                q.push_back(cyc);
                mult_k++; n_hre++;
            end
            if (bus.PE_en) begin
                chk("pe_has_beat", q.size() > 0, 1);
                if (q.size() > 0) begin
                    t0 = q.pop_front();
                    chk("pe_latency", cyc - t0, RL);
                end
                pe_cnt++; n_pe++;
                chk("pe_last", bus.PE_last, pe_cnt == NR);
                if (bus.PE_last) pe_last_cyc = cyc;
            end else begin
                chk("pe_last_alone", bus.PE_last, 0);
            end
            if (bus.hashout_we) begin
                chk("drain_after_pe", pe_cnt, NR);
                chk("out_sel", bus.out_sel, wr_k);
                wr_k++; n_we++;
                if (wr_k == OW) begin
                    hc_exp++; mult_k = 0; pe_cnt = 0; wr_k = 0; last_wr_cyc = cyc;
                end
            end else if (bus.out_full && bus.busy && pe_cnt == NR && q.size() == 0) begin
                chk("out_sel_hold", bus.out_sel, wr_k);
                full_stall++;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_m_re"}, bus.m_re, 0);
        chk({tag, "_m_ram_we"}, bus.m_ram_we, 0);
        chk({tag, "_en_column"}, bus.en_column, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_hashin_re"}, bus.hashin_re, 0);
        chk({tag, "_pe_en"}, bus.PE_en, 0);
        chk({tag, "_pe_clr"}, bus.PE_clr, 1);
        chk({tag, "_pe_last"}, bus.PE_last, 0);
        chk({tag, "_hashout_we"}, bus.hashout_we, 0);
        chk({tag, "_out_sel"}, bus.out_sel, 0);
        chk({tag, "_matrix_valid"}, bus.matrix_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_hash_count"}, bus.hash_count, 0);
    endtask

    task automatic wait_hc(input int target, input int budget);
        int k = 0;
        while (hc_exp < target && k < budget) begin
            @(posedge clk); k++;
        end
        #1 chk("hash_done_in_time", hc_exp >= target, 1);
    endtask

    task automatic wait_load(input int target, input int budget);
        int k = 0;
        while (loads_done < target && k < budget) begin
            @(posedge clk); k++;
        end
        #1 chk("load_done_in_time", loads_done >= target, 1);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (mult_k < target && k < budget) begin
            @(posedge clk); k++;
        end
        chk("beats_in_time", mult_k >= target, 1);
    endtask

    initial begin
        int b_mre, b_hre, b_pe, b_we, b_hc, b_fs;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(posedge clk);
        #2 rst = 1'b0;

        // hashes offered with no matrix resident
        b_hre = n_hre;
        h_goal = n_hre + NR;
        repeat (20) @(posedge clk);
        #1;
        chk("nomat_hashin_re", n_hre - b_hre, 0);
        chk("nomat_busy", bus.busy, 0);
        chk("nomat_mv", bus.matrix_valid, 0);
        h_goal = n_hre;

        // full matrix load, no stalls
        b_mre = n_mre;
        m_goal = n_mre + MAT_WORDS;
        wait_load(1, MAT_WORDS + 100);
        repeat (2) @(posedge clk);
        #1;
        chk("load_beats", n_mre - b_mre, MAT_WORDS);
        chk("load_mv", bus.matrix_valid, 1);

        // single hash, no stalls
        b_hre = n_hre; b_pe = n_pe; b_we = n_we; b_hc = hc_exp;
        h_goal = n_hre + NR;
        wait_hc(b_hc + 1, 400);
        chk("h1_hashin_re", n_hre - b_hre, NR);
        chk("h1_pe_en", n_pe - b_pe, NR);
        chk("h1_writes", n_we - b_we, OW);
        chk("h1_hash_count", bus.hash_count, 1);
        chk("h1_pe_clr_after", bus.PE_clr, 1);

        // back-to-back hashes
        b_hre = n_hre; b_hc = hc_exp;
        h_goal = n_hre + 2 * NR;
        wait_hc(b_hc + 2, 800);
        chk("b2b_hashin_re", n_hre - b_hre, 2 * NR);
        chk("b2b_idle_gap", gap_last, 2);

        // hashin_empty toggling every other cycle
        b_hre = n_hre; b_pe = n_pe; b_hc = hc_exp;
        tog_mode = 1;
        h_goal = n_hre + NR;
        wait_hc(b_hc + 1, 800);
        tog_mode = 0;
        chk("tog_hashin_re", n_hre - b_hre, NR);
        chk("tog_pe_en", n_pe - b_pe, NR);

        // out_full held at drain entry
        b_we = n_we; b_hc = hc_exp; b_fs = full_stall;
        of_mode = 1;
        h_goal = n_hre + NR;
        wait_hc(b_hc + 1, 800);
        of_mode = 0;
        chk("full_writes", n_we - b_we, OW);
        chk("full_stall_cycles", full_stall - b_fs, 10);
        chk("full_hash_count", bus.hash_count, b_hc + 1);

        // random stalls; new matrix arrives mid-hash while a second hash waits
        b_mre = n_mre; b_hc = hc_exp;
        h_rand = 1; of_rand = 1;
        h_goal = n_hre + 2 * NR;
        wait_beats(10, 400);
        m_goal = n_mre + MAT_WORDS;
        wait_hc(b_hc + 2, 20000);
        h_rand = 0; of_rand = 0;
        chk("mid_load_beats", n_mre - b_mre, MAT_WORDS);
        chk("mid_mv", bus.matrix_valid, 1);

        // asynchronous reset during a hash
        h_goal = n_hre + NR;
        wait_beats(30, 400);
        #2 rst = 1'b1;
        h_goal = n_hre;
        #1 check_reset("rst_mid_hash");
        b_we = n_we;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("rst_no_write", n_we - b_we, 0);
        m_rand = 1;
        m_goal = n_mre + MAT_WORDS;
        wait_load(loads_done + 1, 4 * MAT_WORDS);
        m_rand = 0;
        h_goal = n_hre + NR;
        wait_hc(1, 600);
        chk("rst_reload_hash_count", bus.hash_count, 1);
        chk("rst_reload_writes", n_we - b_we, OW);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
